// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order completion buffer between issue and the architectural register file
// Optional RB_BYPASS_EN: FU results captured this cycle are forwarded combinationally onto CDB_data_*.
module reorder_buffer #(
  parameter int WORD_SIZE = 16,
  parameter int RB_INDEX  = 3,
  parameter int RB_SIZE   = 7,
  parameter int READY     = 2**RB_INDEX - 1,
  parameter int FU_NUM    = 4,
  parameter int REG_INDEX = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  input  logic                         alloc_is_branch,
  input  logic [REG_INDEX-1:0]         alloc_dest_reg,
  input  logic [WORD_SIZE-1:0]         alloc_target,
  output logic                         alloc_ready,
  output logic [RB_INDEX-1:0]          alloc_index,
  input  logic [FU_NUM*WORD_SIZE-1:0]  data_bus,
  input  logic [FU_NUM-1:0]            valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]   RB_index_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data,
  output logic [RB_SIZE-1:0]           CDB_data_valid,
  output logic                         commit_valid,
  output logic [REG_INDEX-1:0]         commit_reg,
  output logic [WORD_SIZE-1:0]         commit_data,
  output logic                         redirect_valid,
  output logic [WORD_SIZE-1:0]         redirect_pc,
  output logic [FU_NUM-1:0]            reset_bus
);

  localparam logic [RB_INDEX-1:0] LAST_IDX  = RB_INDEX'(RB_SIZE - 1);
  localparam logic [RB_INDEX-1:0] READY_IDX = RB_INDEX'(READY);
  localparam logic [RB_INDEX-1:0] SIZE_CNT  = RB_INDEX'(RB_SIZE);

  logic [RB_INDEX-1:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic                 flush_pending_q, flush_pending_d;
  logic [RB_SIZE-1:0]   busy_q, busy_d, done_q, done_d, br_q, br_d;
  logic [REG_INDEX-1:0] dest_q   [RB_SIZE];
  logic [REG_INDEX-1:0] dest_d   [RB_SIZE];
  logic [WORD_SIZE-1:0] target_q [RB_SIZE];
  logic [WORD_SIZE-1:0] target_d [RB_SIZE];
  logic [WORD_SIZE-1:0] value_q  [RB_SIZE];
  logic [WORD_SIZE-1:0] value_d  [RB_SIZE];

  logic                 commit_valid_q, commit_valid_d;
  logic [REG_INDEX-1:0] commit_reg_q, commit_reg_d;
  logic [WORD_SIZE-1:0] commit_data_q, commit_data_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [WORD_SIZE-1:0] redirect_pc_q, redirect_pc_d;
  logic [FU_NUM-1:0]    reset_bus_q, reset_bus_d;

  logic [RB_SIZE-1:0]   cap_hit;
  logic [WORD_SIZE-1:0] cap_data [RB_SIZE];
  logic                 do_alloc, do_commit, do_flush;

  function automatic logic [RB_INDEX-1:0] wrap_inc(input logic [RB_INDEX-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + RB_INDEX'(1);
  endfunction

  assign alloc_ready = (count_q < SIZE_CNT) && !flush_pending_q;
  assign alloc_index = tail_q;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_commit   = busy_q[head_q] && done_q[head_q];
  assign do_flush    = do_commit && br_q[head_q] && value_q[head_q][0];

  // Scan FUs from highest to lowest so the lowest-numbered FU wins a shared entry.
  always_comb begin
    cap_hit = '0;
    for (int k = 0; k < RB_SIZE; k++) begin
      cap_data[k] = '0;
      for (int i = FU_NUM - 1; i >= 0; i--) begin
        if (valid_bus[i] && RB_index_bus[i*RB_INDEX +: RB_INDEX] != READY_IDX &&
            RB_index_bus[i*RB_INDEX +: RB_INDEX] == RB_INDEX'(k) &&
            busy_q[k] && !done_q[k]) begin
          cap_hit[k]  = 1'b1;
          cap_data[k] = data_bus[i*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    flush_pending_d = 1'b0;
    busy_d          = busy_q;
    done_d          = done_q | cap_hit;
    br_d            = br_q;
    dest_d          = dest_q;
    target_d        = target_q;
    for (int k = 0; k < RB_SIZE; k++) begin
      value_d[k] = cap_hit[k] ? cap_data[k] : value_q[k];
    end
    commit_valid_d   = 1'b0;
    commit_reg_d     = '0;
    commit_data_d    = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    reset_bus_d      = '0;

    if (do_alloc) begin
      busy_d[tail_q]   = 1'b1;
      done_d[tail_q]   = 1'b0;
      br_d[tail_q]     = alloc_is_branch;
      dest_d[tail_q]   = alloc_dest_reg;
      target_d[tail_q] = alloc_target;
      tail_d           = wrap_inc(tail_q);
    end

    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = wrap_inc(head_q);
      if (!br_q[head_q]) begin
        commit_valid_d = 1'b1;
        commit_reg_d   = dest_q[head_q];
        commit_data_d  = value_q[head_q];
      end
    end

    count_d = count_q + RB_INDEX'(do_alloc) - RB_INDEX'(do_commit);

    // A taken branch at the head overrides any alloc or capture on the same edge.
    if (do_flush) begin
      busy_d           = '0;
      done_d           = '0;
      br_d             = '0;
      dest_d           = '{default: '0};
      target_d         = '{default: '0};
      value_d          = '{default: '0};
      head_d           = '0;
      tail_d           = '0;
      count_d          = '0;
      flush_pending_d  = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = target_q[head_q];
      reset_bus_d      = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      flush_pending_q  <= 1'b0;
      busy_q           <= '0;
      done_q           <= '0;
      br_q             <= '0;
      dest_q           <= '{default: '0};
      target_q         <= '{default: '0};
      value_q          <= '{default: '0};
      commit_valid_q   <= 1'b0;
      commit_reg_q     <= '0;
      commit_data_q    <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      reset_bus_q      <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      flush_pending_q  <= flush_pending_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      br_q             <= br_d;
      dest_q           <= dest_d;
      target_q         <= target_d;
      value_q          <= value_d;
      commit_valid_q   <= commit_valid_d;
      commit_reg_q     <= commit_reg_d;
      commit_data_q    <= commit_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      reset_bus_q      <= reset_bus_d;
    end
  end

  assign commit_valid   = commit_valid_q;
  assign commit_reg     = commit_reg_q;
  assign commit_data    = commit_data_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign reset_bus      = reset_bus_q;

  always_comb begin
    CDB_data_valid = '0;
    CDB_data_data  = '0;
    for (int k = 0; k < RB_SIZE; k++) begin
`ifdef RB_BYPASS_EN
      CDB_data_valid[k] = (busy_q[k] & done_q[k]) | cap_hit[k];
      CDB_data_data[k*WORD_SIZE +: WORD_SIZE] = cap_hit[k] ? cap_data[k] : value_q[k];
`else
      CDB_data_valid[k] = busy_q[k] & done_q[k];
      CDB_data_data[k*WORD_SIZE +: WORD_SIZE] = value_q[k];
`endif
    end
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order completion buffer for the Tomasulo core. It sits between issue and the architectural register file.
- Issue allocates one entry per instruction; the entry index becomes the RB_index handed to the reservation stations.
- Functional units (ALU, branch RS, ...) return results on the FU result buses. The buffer republishes completed entries on CDB_data_* so that waiting reservation stations can capture operands.
- Entries commit in program order. A taken branch at the head flushes the machine and resets all FUs.

Parameters:
- WORD_SIZE, 16, data word width
- RB_INDEX, 3, entry index width
- RB_SIZE, 7, entry count; must be ≤ 2^RB_INDEX-1
- READY, 2^RB_INDEX-1, reserved index meaning "no entry / operand ready"; never allocated
- FU_NUM, 4, number of functional units on the result buses
- REG_INDEX, 3, architectural register index width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- alloc_valid  in  1  issue requests an entry
- alloc_is_branch  in  1  entry holds a branch; its result bit0 = taken
- alloc_dest_reg  in  REG_INDEX  destination register (ignored for branches)
- alloc_target  in  WORD_SIZE  branch target PC (ignored for non-branches)
- alloc_ready  out  1  an entry is available
- alloc_index  out  RB_INDEX  index that will be assigned (tail pointer)
- data_bus  in  FU_NUM*WORD_SIZE  FU results, slice i belongs to FU i
- valid_bus  in  FU_NUM  FU result valid
- RB_index_bus  in  FU_NUM*RB_INDEX  destination entry per FU
- CDB_data_data  out  WORD_SIZE*RB_SIZE  per-entry result value
- CDB_data_valid  out  RB_SIZE  per-entry result-available flag
- commit_valid  out  1  one-cycle pulse: register write
- commit_reg  out  REG_INDEX  register being written
- commit_data  out  WORD_SIZE  value being written
- redirect_valid  out  1  one-cycle pulse: taken branch committed
- redirect_pc  out  WORD_SIZE  branch target
- reset_bus  out  FU_NUM  per-FU reset; all ones for one cycle on flush

Behaviour:
- Reset (async):
  - head = tail = count = 0; all entries cleared.
  - All outputs 0 except alloc_ready = 1 and alloc_index = 0.
- Per-entry state: busy, done, is_branch, dest_reg, target, value.
- alloc_ready = (count < RB_SIZE) && !flush_pending. It is computed from registered state only.
- Allocation: on a posedge with alloc_valid && alloc_ready:
  - Entry[tail] gets busy=1, done=0 and the alloc fields.
  - tail advances, wrapping RB_SIZE-1 → 0.
  - alloc_valid while not ready is ignored; no state change.
- Capture: on a posedge, for each FU i with valid_bus[i]=1 and RB_index_bus slice i ≠ READY:
  - If the target entry is busy and not done, set value = data slice and done=1.
  - Writes to a non-busy or already-done entry are dropped.
  - Two FUs naming the same entry in one cycle: the lowest FU index wins.
- CDB outputs (registered):
  - CDB_data_valid[k] = busy[k] & done[k].
  - CDB_data_data slice k = value[k].
  - Latency: FU valid at edge N → CDB valid after edge N+1.
  - Flags stay high until the entry commits or is flushed.
- Commit: at most one per cycle, from head, when busy[head] & done[head]. The entry is freed and head advances with wrap.
  - Non-branch: commit_valid=1, commit_reg and commit_data set for one cycle.
  - Branch, value[0]=0 (not taken): entry retires silently.
  - Branch, value[0]=1 (taken):
    - redirect_valid=1 and redirect_pc=target, one cycle.
    - All entries cleared; head = tail = count = 0.
    - reset_bus = all ones for that cycle; flush_pending=1 for that cycle, forcing alloc_ready=0.
- Simultaneous events:
  - Alloc plus non-flush commit in the same edge: count unchanged.
  - Capture into the head entry on the same edge it would otherwise commit: it commits on the next edge.
  - Flush beats alloc and capture on the same edge.
- reset asserted mid-operation discards all entries immediately; no commit or redirect pulse is emitted.

Optional Feature:
- RB_BYPASS_EN:
  - Defined: CDB_data_valid/CDB_data_data additionally OR in, combinationally, any capture occurring in the current cycle. A reservation station sees the result in the same cycle the FU asserts valid, which removes one cycle of latency.
  - Undefined: purely registered, as specified in Behaviour.

Test Plan:
- After reset, 7 allocs on consecutive cycles → alloc_index 0..6, alloc_ready drops to 0 after the 7th, and an 8th alloc_valid is ignored.
- Alloc entry 0 (reg 3), FU1 returns 0x1234 for index 0 → CDB_data_valid[0]=1 one edge later, then commit_valid pulse with reg 3, data 0x1234.
- Entries 0 and 1 allocated; entry 1 completes first → no commit until entry 0 completes, then commits on consecutive cycles in order 0, 1.
- Branch at entry 2 (target 0x0040) returns 1, entries 3–4 allocated → redirect_valid with pc 0x0040, reset_bus=4'b1111 for one cycle, count=0, entries 3–4 are never committed.
- Branch returns 0 → no redirect, no reset_bus, and the following entry commits normally.
- Fill to head=5, then commit and allocate across the wrap → tail goes 6→0 correctly; FU writes with index READY(7) are ignored.
